// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges byte-stream requesters into one UART transmit stream.
// Each grant optionally starts with a header byte (8'hA0 | grant) and carries at most MAX_LEN payload bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_LEN   = 64,
  parameter int HEADER_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  // Handshake: a byte moves on a rising edge where valid and ready are both high.
  // The grant's req_valid/req_ready pass straight through to out_valid/out_ready in PAYLOAD.

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  localparam logic [GW:0]   NUM_REQ_W = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  logic [1:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    count;

  logic [7:0]    req_byte [NUM_REQ];
  logic [GW:0]   scan_idx;
  logic [GW-1:0] pick;
  logic          any_valid;
  logic          pay_xfer;
  logic          seg_end;
  logic [7:0]    count_inc;
  logic [GW-1:0] next_ptr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[i*8 +: 8];
    end
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        pick      = scan_idx[GW-1:0];
      end
    end
  end

  assign pay_xfer  = (state == S_PAYLOAD) && req_valid[grant] && out_ready;
  assign count_inc = count + 8'd1;
  // A packet end and hitting the length cap on the same byte release the grant once.
  assign seg_end   = req_last[grant] || (count_inc == MAX_LEN_B);
  assign next_ptr  = (grant == LAST_REQ) ? '0 : grant + GW'(1);

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    req_ready = '0;
    case (state)
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = 8'hA0 | 8'(grant);
      end
      S_PAYLOAD: begin
        out_valid        = req_valid[grant];
        out_data         = req_byte[grant];
        req_ready[grant] = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      count  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            grant <= pick;
            count <= 8'd0;
            state <= (HEADER_EN != 0) ? S_HEADER : S_PAYLOAD;
          end
        end
        S_HEADER: begin
          if (out_ready) begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (pay_xfer) begin
            count <= count_inc;
            if (seg_end) begin
              state  <= S_IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign grant_id  = grant;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte streams feed a segment-level reference model whose
// expected output bytes go into a queue that a negedge monitor pops on every output transfer.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int ML = 4;
  localparam int SD = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic [1:0]      state_dbg;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .HEADER_EN(1)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .state_dbg(state_dbg)
  );

  // Second instance: no header, one byte per grant.
  logic        b_rst = 1'b1;
  logic [15:0] b_req_data = 16'h0100;
  logic [1:0]  b_req_valid = 2'b11;
  logic [1:0]  b_req_last = 2'b00;
  logic [1:0]  b_req_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [0:0]  b_grant_id;
  logic        b_busy;
  logic [1:0]  b_state_dbg;

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_LEN(1), .HEADER_EN(0)) dut_b (
    .clk(clk), .rst(b_rst), .req_data(b_req_data), .req_valid(b_req_valid), .req_last(b_req_last),
    .req_ready(b_req_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .grant_id(b_grant_id), .busy(b_busy), .state_dbg(b_state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Per-requester byte streams: {last, data}
  logic [8:0] strm [NR][SD];
  int strm_len [NR];
  int drv_pos  [NR];
  int m_pos    [NR];

  int valid_mode = 0;  // 0: valid whenever data exists, 1: random start delays
  int ready_mode = 0;  // 0: always ready, 1: random, 2: low 5 of every 7 cycles
  int rst_cnt    = 2;
  bit abandon    = 1'b0;
  int cyc        = 0;

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    strm[r][strm_len[r]] = {last, d};
    strm_len[r]++;
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      add_byte(r, 8'($urandom_range(0, 255)), (k == len - 1));
    end
  endtask

  // ---------------- driver ----------------
  logic [NR-1:0] drv_hs;
  logic [NR-1:0] drv_v = '0;
  logic [8:0]    cur;

  initial begin
    for (int i = 0; i < NR; i++) begin
      strm_len[i] = 0;
      drv_pos[i]  = 0;
      m_pos[i]    = 0;
    end
  end

  always begin
    @(negedge clk);
    drv_hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    rst = (rst_cnt > 0);
    if (rst_cnt > 0) rst_cnt--;
    for (int i = 0; i < NR; i++) begin
      if (drv_hs[i]) begin
        drv_pos[i]++;
        drv_v[i] = 1'b0;
      end
    end
    if (abandon) begin
      drv_pos[0] = strm_len[0];
      abandon    = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (drv_pos[i] < strm_len[i]) begin
        if (!drv_v[i] && (valid_mode == 0 || $urandom_range(0, 99) < 55)) drv_v[i] = 1'b1;
        cur = strm[i][drv_pos[i]];
      end else begin
        drv_v[i] = 1'b0;
        cur = 9'($urandom_range(0, 511));
      end
      req_valid[i]       = drv_v[i];
      req_last[i]        = drv_v[i] ? cur[8] : 1'($urandom_range(0, 1));
      req_data[i*8 +: 8] = cur[7:0];
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 65);
      default: out_ready = ((cyc % 7) >= 5);
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         m_idle = 1'b1;
  bit         m_hdr  = 1'b0;
  int         m_g    = 0;
  int         m_ptr  = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    int g;
    int n;
    logic [8:0] b;
    logic [7:0] e;
    if (rst) begin
      exp_q.delete();
      m_idle = 1'b1;
      m_hdr  = 1'b0;
      m_g    = 0;
      m_ptr  = 0;
      prev_stall = 1'b0;
      for (int i = 0; i < NR; i++) m_pos[i] = drv_pos[i];
    end else begin
      if (busy) busy_cnt++;
      chk("grant_id", 32'(grant_id), 32'(m_g));
      if (prev_stall) chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      if (m_idle) begin
        chk("idle_outputs", {27'd0, busy, out_valid, req_ready}, 32'd0);
        if (req_valid != '0) begin
          g = -1;
          for (int k = 0; k < NR; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
          end
          exp_q.push_back(8'hA0 | 8'(g));
          n = 0;
          do begin
            b = strm[g][m_pos[g]];
            m_pos[g]++;
            exp_q.push_back(b[7:0]);
            n++;
          end while (!b[8] && n < ML);
          m_g    = g;
          m_idle = 1'b0;
          m_hdr  = 1'b1;
        end
      end else begin
        chk("busy", 32'(busy), 32'd1);
        chk("req_ready", 32'(req_ready), (m_hdr || !out_ready) ? 32'd0 : (32'd1 << m_g));
        chk("out_valid", 32'(out_valid), m_hdr ? 32'd1 : 32'(req_valid[m_g]));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk(m_hdr ? "header" : "payload", 32'(out_data), 32'(e));
          end
          m_hdr = 1'b0;
          if (exp_q.size() == 0) begin
            m_idle = 1'b1;
            m_ptr  = (m_g + 1) % NR;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_reset();
    rst_cnt = 2;
    repeat (4) step();
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = m_idle && (exp_q.size() == 0) && !rst;
      for (int i = 0; i < NR; i++) if (drv_pos[i] != strm_len[i]) done = 1'b0;
    end
    chk(name, 32'(done), 32'd1);
    repeat (2) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start0;
    bit hit;
    repeat (4) step();

    // single requester, three bytes
    pulse_reset();
    valid_mode = 0; ready_mode = 0;
    busy_cnt = 0;
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b0);
    add_byte(2, 8'h33, 1'b1);
    drain("drain_single", 100);
    chk("busy_cycles_single", 32'(busy_cnt), 32'd4);

    // round robin over 0,1,3 with one-byte packets
    pulse_reset();
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 1); add_pkt(1, 1); add_pkt(3, 1);
    end
    drain("drain_rr", 200);

    // length cap splits a 6-byte packet
    pulse_reset();
    add_pkt(1, 6);
    drain("drain_cap", 200);

    // long back-pressure stalls in header and payload
    pulse_reset();
    ready_mode = 2;
    add_pkt(0, 3); add_pkt(2, 2);
    drain("drain_bp", 400);

    // reset in the middle of requester 0's packet; requester 1 waiting
    pulse_reset();
    ready_mode = 0;
    start0 = drv_pos[0];
    add_pkt(0, 5); add_pkt(1, 1);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      step();
      hit = (drv_pos[0] >= start0 + 2);
    end
    chk("reach_mid_packet", 32'(hit), 32'd1);
    abandon = 1'b1;
    rst_cnt = 2;
    drain("drain_after_reset", 200);

    // randomized streams with random valid and ready
    pulse_reset();
    valid_mode = 1; ready_mode = 1;
    for (int r = 0; r < NR; r++) begin
      for (int p = 0; p < 8; p++) add_pkt(r, $urandom_range(1, 9));
    end
    drain("drain_random", 20000);

    // no-header, single-byte grants alternate between two streaming requesters
    step();
    b_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b_out_valid", 32'(b_out_valid), 32'(k % 2));
      chk("b_busy", 32'(b_busy), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("b_out_data", 32'(b_out_data), 32'(((k - 1) / 2) % 2));
        chk("b_grant_id", 32'(b_grant_id), 32'(((k - 1) / 2) % 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
